// File: rtl/pong_pkg.sv
// Shared encodings and widths for the pong game controller.
package pong_pkg;

    localparam int SCORE_W     = 4;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_SERVE = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

endpackage

// File: rtl/pong_btn_sync.sv
// Start button conditioning: two-flop synchroniser plus rising-edge detector.
// A button already held when reset releases must be let go before it can
// start a game, so the detector only arms after a genuine synchronised low.
module pong_btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       armed_q;
    logic       armed_d;
    logic [1:0] fill_q;

    // Synchroniser chain, edge history and the arming flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_d;
        end
    end

    // Arm once sync2 holds a real sampled low, then emit one-clk rising pulses
    always_comb begin
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
        pulse_o = armed_q & sync2_q & ~prev_q;
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game flow controller: serve pause, scoring, win detection and the
// game-over display timer.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 10,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               refresh_tick,
    input  logic               goal_left,
    input  logic               goal_right,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic               point_evt
);

    localparam logic [SCORE_W-1:0]     WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] OVER_LAST  = FRAME_CNT_W'(OVER_FRAMES - 1);

    state_e                 state_q, state_d;
    winner_e                winner_q, winner_d;
    logic [SCORE_W-1:0]     score1_q, score1_d;
    logic [SCORE_W-1:0]     score2_q, score2_d;
    logic [SCORE_W-1:0]     score1_inc, score2_inc;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   serve_dir_q, serve_dir_d;
    logic                   point_q, point_d;
    logic                   start_pulse;
    logic                   new_game;

    pong_btn_sync u_btn_sync (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (start_btn),
        .pulse_o (start_pulse)
    );

    // State register together with scores, winner, serve direction and frame counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            score1_q    <= '0;
            score2_q    <= '0;
            winner_q    <= WIN_NONE;
            serve_dir_q <= 1'b0;
            point_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            winner_q    <= winner_d;
            serve_dir_q <= serve_dir_d;
            point_q     <= point_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Phase transitions; goal_left is checked first so it wins a simultaneous goal
    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        frame_cnt_d = frame_cnt_q;
        point_d     = 1'b0;
        new_game    = 1'b0;
        score1_inc  = score1_q + 1'b1;
        score2_inc  = score2_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                new_game = start_pulse;
            end
            ST_SERVE: begin
                if (refresh_tick) begin
                    if (frame_cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (goal_left) begin
                    score2_d    = score2_inc;
                    serve_dir_d = 1'b0;
                    point_d     = 1'b1;
                    frame_cnt_d = '0;
                    if (score2_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_P2;
                    end else begin
                        state_d  = ST_SERVE;
                    end
                end else if (goal_right) begin
                    score1_d    = score1_inc;
                    serve_dir_d = 1'b1;
                    point_d     = 1'b1;
                    frame_cnt_d = '0;
                    if (score1_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_P1;
                    end else begin
                        state_d  = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_pulse) begin
                    new_game = 1'b1;
                end else if (refresh_tick) begin
                    if (frame_cnt_q == OVER_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (new_game) begin
            state_d     = ST_SERVE;
            score1_d    = '0;
            score2_d    = '0;
            winner_d    = WIN_NONE;
            serve_dir_d = 1'b1;
            frame_cnt_d = '0;
        end
    end

    // Output decode straight from the registers, ball held while idle or serving
    always_comb begin
        state      = state_q;
        score1     = score1_q;
        score2     = score2_q;
        winner     = winner_q;
        serve_dir  = serve_dir_q;
        point_evt  = point_q;
        ball_reset = (state_q == ST_IDLE) || (state_q == ST_SERVE);
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed, table-driven bench for pong_game_ctrl. A WIN_SCORE=3 instance is
// checked through full games; a default-parameter instance sharing the same
// inputs is used for the long mid-game asynchronous reset scenario.
module tb_pong_game_ctrl;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] PLAY  = 2'b01;
    localparam logic [1:0] SERVE = 2'b10;
    localparam logic [1:0] OVER  = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       startBtn;
    logic       refreshTick;
    logic       goalLeft;
    logic       goalRight;

    logic [1:0] state,  stateB;
    logic [3:0] score1, score1B;
    logic [3:0] score2, score2B;
    logic [1:0] winner, winnerB;
    logic       ballReset, ballResetB;
    logic       serveDir,  serveDirB;
    logic       pointEvt,  pointEvtB;

    int checksTotal  = 0;
    int checksPassed = 0;

    typedef struct {
        string      name;
        logic       start;
        logic       tick;
        logic       gl;
        logic       gr;
        logic [1:0] expState;
        logic [3:0] expScore1;
        logic [3:0] expScore2;
        logic [1:0] expWinner;
        logic       expBallReset;
        logic       expServeDir;
        logic       expPointEvt;
    } vec_t;

    vec_t vecTable[$];

    pong_game_ctrl #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (60),
        .OVER_FRAMES  (180)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_btn    (startBtn),
        .refresh_tick (refreshTick),
        .goal_left    (goalLeft),
        .goal_right   (goalRight),
        .state        (state),
        .score1       (score1),
        .score2       (score2),
        .winner       (winner),
        .ball_reset   (ballReset),
        .serve_dir    (serveDir),
        .point_evt    (pointEvt)
    );

    pong_game_ctrl dutB (
        .clk          (clk),
        .reset        (reset),
        .start_btn    (startBtn),
        .refresh_tick (refreshTick),
        .goal_left    (goalLeft),
        .goal_right   (goalRight),
        .state        (stateB),
        .score1       (score1B),
        .score2       (score2B),
        .winner       (winnerB),
        .ball_reset   (ballResetB),
        .serve_dir    (serveDirB),
        .point_evt    (pointEvtB)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 ns later
    task automatic applyStimulus(input logic s, input logic t, input logic gl, input logic gr);
        startBtn    = s;
        refreshTick = t;
        goalLeft    = gl;
        goalRight   = gr;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input string name, input logic s, input logic t, input logic gl, input logic gr,
                          input logic [1:0] st, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [1:0] w, input logic br, input logic sd, input logic pe);
        vec_t v;
        v.name = name; v.start = s; v.tick = t; v.gl = gl; v.gr = gr;
        v.expState = st; v.expScore1 = s1; v.expScore2 = s2; v.expWinner = w;
        v.expBallReset = br; v.expServeDir = sd; v.expPointEvt = pe;
        vecTable.push_back(v);
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, "/state"},     8'(state),     8'(v.expState));
        checkOutput({v.name, "/score1"},    8'(score1),    8'(v.expScore1));
        checkOutput({v.name, "/score2"},    8'(score2),    8'(v.expScore2));
        checkOutput({v.name, "/winner"},    8'(winner),    8'(v.expWinner));
        checkOutput({v.name, "/ballReset"}, 8'(ballReset), 8'(v.expBallReset));
        checkOutput({v.name, "/serveDir"},  8'(serveDir),  8'(v.expServeDir));
        checkOutput({v.name, "/pointEvt"},  8'(pointEvt),  8'(v.expPointEvt));
    endtask

    task automatic runRange(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            applyStimulus(vecTable[i].start, vecTable[i].tick, vecTable[i].gl, vecTable[i].gr);
            checkVector(vecTable[i]);
        end
    endtask

    task automatic runTicks(input int n, input logic s);
        for (int i = 0; i < n; i++) begin
            applyStimulus(s, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Full serve pause on the main instance: still serving after 59 ticks, playing after 60
    task automatic serveDut();
        runTicks(59, 1'b0);
        checkOutput("serve_tick59_state", 8'(state), 8'(SERVE));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("serve_tick60_state", 8'(state), 8'(PLAY));
        checkOutput("serve_tick60_ballReset", 8'(ballReset), 8'd0);
    endtask

    // Main test sequence
    initial begin
        int secStart, secPlay, secSimul, secGoal2, secGoal3, secNew, secNewGoals, secRace;
        logic [1:0] ngState, ngWin;
        logic       ngBr;

        secStart = vecTable.size();
        addVec("start_e1",    1,0,0,0, IDLE, 0,0,2'b00, 1,0,0);
        addVec("start_e2",    1,0,0,0, IDLE, 0,0,2'b00, 1,0,0);
        addVec("start_e3",    1,0,0,0, SERVE,0,0,2'b00, 1,1,0);
        addVec("start_hold4", 1,0,0,0, SERVE,0,0,2'b00, 1,1,0);
        addVec("start_hold5", 1,0,0,0, SERVE,0,0,2'b00, 1,1,0);
        addVec("start_rel",   0,0,0,0, SERVE,0,0,2'b00, 1,1,0);

        secPlay = vecTable.size();
        addVec("play_start1",  1,0,0,0, PLAY, 0,0,2'b00, 0,1,0);
        addVec("play_start2",  1,0,0,0, PLAY, 0,0,2'b00, 0,1,0);
        addVec("play_start3",  1,0,0,0, PLAY, 0,0,2'b00, 0,1,0);
        addVec("play_rel",     0,0,0,0, PLAY, 0,0,2'b00, 0,1,0);
        addVec("goal_r",       0,0,0,1, SERVE,1,0,2'b00, 1,1,1);
        addVec("goal_r_after", 0,0,0,0, SERVE,1,0,2'b00, 1,1,0);
        addVec("serve_goal_l", 0,0,1,0, SERVE,1,0,2'b00, 1,1,0);
        addVec("serve_idle",   0,0,0,0, SERVE,1,0,2'b00, 1,1,0);

        secSimul = vecTable.size();
        addVec("both_goals",   0,0,1,1, SERVE,1,1,2'b00, 1,0,1);
        addVec("both_after",   0,0,0,0, SERVE,1,1,2'b00, 1,0,0);

        secGoal2 = vecTable.size();
        addVec("goal_l2",       0,0,1,0, SERVE,1,2,2'b00, 1,0,1);
        addVec("goal_l2_after", 0,0,0,0, SERVE,1,2,2'b00, 1,0,0);

        secGoal3 = vecTable.size();
        addVec("goal_l3_win",  0,0,1,0, OVER, 1,3,2'b10, 0,0,1);
        addVec("over_goal_r",  0,0,0,1, OVER, 1,3,2'b10, 0,0,0);
        addVec("over_goal_l",  0,0,1,0, OVER, 1,3,2'b10, 0,0,0);

        secNew = vecTable.size();
        addVec("new_e1",  1,0,0,0, IDLE, 1,3,2'b10, 1,0,0);
        addVec("new_e2",  1,0,0,0, IDLE, 1,3,2'b10, 1,0,0);
        addVec("new_e3",  1,0,0,0, SERVE,0,0,2'b00, 1,1,0);
        addVec("new_rel", 0,0,0,0, SERVE,0,0,2'b00, 1,1,0);

        secNewGoals = vecTable.size();
        for (int k = 1; k <= 3; k++) begin
            ngState = (k == 3) ? OVER : SERVE;
            ngWin   = (k == 3) ? 2'b10 : 2'b00;
            ngBr    = (k == 3) ? 1'b0 : 1'b1;
            addVec("ng_goal",  0,0,1,0, ngState,0,4'(k),ngWin, ngBr,0,1);
            addVec("ng_after", 0,0,0,0, ngState,0,4'(k),ngWin, ngBr,0,0);
        end

        secRace = vecTable.size();
        addVec("race_t178", 1,1,0,0, OVER, 0,3,2'b10, 0,0,0);
        addVec("race_t179", 1,1,0,0, OVER, 0,3,2'b10, 0,0,0);
        addVec("race_t180", 1,1,0,0, SERVE,0,0,2'b00, 1,1,0);
        addVec("race_rel",  0,0,0,0, SERVE,0,0,2'b00, 1,1,0);

        reset       = 1'b1;
        startBtn    = 1'b0;
        refreshTick = 1'b0;
        goalLeft    = 1'b0;
        goalRight   = 1'b0;
        #12;
        checkOutput("rst_state",     8'(state),     8'(IDLE));
        checkOutput("rst_score1",    8'(score1),    8'd0);
        checkOutput("rst_score2",    8'(score2),    8'd0);
        checkOutput("rst_winner",    8'(winner),    8'd0);
        checkOutput("rst_ballReset", 8'(ballReset), 8'd1);
        checkOutput("rst_serveDir",  8'(serveDir),  8'd0);
        checkOutput("rst_pointEvt",  8'(pointEvt),  8'd0);
        reset = 1'b0;
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] start and first serve");
        runRange(secStart, 6);
        serveDut();
        $display("[TB] goals in play and serve");
        runRange(secPlay, 8);
        serveDut();
        runRange(secSimul, 2);
        serveDut();
        runRange(secGoal2, 2);
        serveDut();
        runRange(secGoal3, 3);

        $display("[TB] game-over timeout");
        runTicks(179, 1'b0);
        checkOutput("over_tick179_state", 8'(state), 8'(OVER));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("over_tick180_state",  8'(state),  8'(IDLE));
        checkOutput("over_tick180_score2", 8'(score2), 8'd3);
        checkOutput("over_tick180_winner", 8'(winner), 8'(2'b10));

        $display("[TB] new game then start racing the timeout");
        runRange(secNew, 4);
        for (int k = 0; k < 3; k++) begin
            serveDut();
            runRange(secNewGoals + 2 * k, 2);
        end
        runTicks(177, 1'b0);
        runRange(secRace, 4);

        $display("[TB] mid-game async reset on default instance");
        reset = 1'b1;
        #2;
        reset = 1'b0;
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b_start_state", 8'(stateB), 8'(SERVE));
        for (int k = 0; k < 7; k++) begin
            runTicks(60, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("b_seven_score1", 8'(score1B), 8'd7);
        runTicks(60, 1'b0);
        checkOutput("b_midplay_state",  8'(stateB),  8'(PLAY));
        checkOutput("b_midplay_score1", 8'(score1B), 8'd7);

        startBtn = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("b_async_state",     8'(stateB),     8'(IDLE));
        checkOutput("b_async_score1",    8'(score1B),    8'd0);
        checkOutput("b_async_score2",    8'(score2B),    8'd0);
        checkOutput("b_async_winner",    8'(winnerB),    8'd0);
        checkOutput("b_async_ballReset", 8'(ballResetB), 8'd1);
        checkOutput("b_async_serveDir",  8'(serveDirB),  8'd0);
        checkOutput("b_async_pointEvt",  8'(pointEvtB),  8'd0);
        checkOutput("a_async_state",     8'(state),      8'(IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b_held_state",    8'(stateB),    8'(IDLE));
        checkOutput("b_held_pointEvt", 8'(pointEvtB), 8'd0);
        checkOutput("b_held_winner",   8'(winnerB),   8'd0);
        checkOutput("b_held_score1",   8'(score1B),   8'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b_repress_state", 8'(stateB), 8'(SERVE));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 10, points that end a game (legal range 1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, refresh_tick count of the pre-serve pause (legal range 1..255).
REQ-003 SHALL have parameter OVER_FRAMES, default 180, refresh_tick count of the game-over display before returning to idle (legal range 1..255).
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 start_btn  in  1  raw, asynchronous push-button level.
REQ-007 refresh_tick  in  1  one-clk pulse per video frame.
REQ-008 goal_left  in  1  one-clk pulse: ball reached the left wall, so player 2 scores.
REQ-009 goal_right  in  1  one-clk pulse: ball reached the right wall, so player 1 scores.
REQ-010 state  out  2  game phase: 00 IDLE, 01 PLAY, 10 SERVE, 11 OVER.
REQ-011 score1, score2  out  4 each  player points, unsigned.
REQ-012 winner  out  2  00 none, 01 player 1, 10 player 2.
REQ-013 ball_reset  out  1  high: graphics holds ball at centre, paddles frozen.
REQ-014 serve_dir  out  1  initial ball x-direction: 0 left, 1 right.
REQ-015 point_evt  out  1  one-clk pulse on every accepted goal.

Function
REQ-016 start_btn SHALL pass a 2-flop synchroniser then a rising-edge detector; start_pulse is one clk wide and state responds on the 3rd rising clk edge at which start_btn is sampled high.
REQ-017 IDLE: on start_pulse -> SERVE; same edge: scores cleared, winner <= 00, serve_dir <= 1, frame counter loaded.
REQ-018 SERVE: counts refresh_ticks; on the edge of the SERVE_FRAMES-th tick counted in SERVE -> PLAY.
REQ-019 PLAY: goal_left -> score2 +1, serve_dir <= 0; goal_right -> score1 +1, serve_dir <= 1; point_evt asserted in the following cycle for exactly one clk.
REQ-020 PLAY goal: if the incremented score equals WIN_SCORE -> OVER with winner set to that player, else -> SERVE with counter reloaded; same edge as the score update.
REQ-021 goal_left and goal_right both high in one cycle: goal_left takes priority; goal_right ignored.
REQ-022 Goals outside PLAY SHALL be ignored (no score change, no point_evt).
REQ-023 OVER: on the OVER_FRAMES-th refresh_tick -> IDLE; scores and winner held.
REQ-024 OVER: start_pulse before timeout -> SERVE as in REQ-017; start_pulse in SERVE or PLAY ignored.
REQ-025 start_pulse and refresh_tick-timeout in the same OVER cycle: start_pulse wins.
REQ-026 ball_reset SHALL be high exactly when state is IDLE or SERVE (registered with state, no extra latency).
REQ-027 Scores SHALL never exceed WIN_SCORE; no wrap-around.
REQ-028 Frame counter 8 bits, loaded to 0 on entering SERVE/OVER and compared against parameter-1; refresh_tick in PLAY/IDLE does not alter it.
REQ-029 winner SHALL be 00 whenever state is IDLE-after-new-start, SERVE or PLAY of a new game; held non-zero only from the OVER entry until the next start.

Reset
REQ-030 reset SHALL immediately force: state IDLE, score1/score2 0, winner 00, serve_dir 0, ball_reset 1, point_evt 0, frame counter 0, synchroniser/edge flops 0.
REQ-031 reset asserted mid-game SHALL abandon the game; no point_evt or winner produced on or after release until new play.
REQ-032 A start_btn already held high at reset release SHALL NOT produce start_pulse until released and pressed again.

Structure
REQ-033 Shared package pong_pkg SHALL hold the state encodings, winner encodings, SCORE_W=4 and FRAME_CNT_W=8.
REQ-034 One sub-module pong_btn_sync SHALL implement synchroniser plus edge detect; FSM, counters and scores live in pong_game_ctrl.

Verification
REQ-035 Reset then start_btn held 5 clks -> state 10 on 3rd sampling edge, ball_reset 1, scores 0; after 60 refresh_ticks state 01, ball_reset 0.
REQ-036 In PLAY, goal_right pulse -> score1 1, serve_dir 1, state 10, point_evt one clk next cycle; goal_left in SERVE -> no change.
REQ-037 WIN_SCORE=3: three goal_left pulses each after serve -> score2 3, state 11, winner 10; 180 ticks later state 00, score2 still 3.
REQ-038 Simultaneous goal_left and goal_right in PLAY -> only score2 increments.
REQ-039 In OVER, start press on the same cycle as final timeout tick -> state 10, scores 0, winner 00.
REQ-040 Async reset asserted mid-PLAY with score1=7 -> outputs to reset values without waiting for clk; held start_btn after release gives no start.
